// File: rtl/wb_mem_arbiter.sv
// Two-master Wishbone arbiter (CPU m0, debug/boot m1) in front of one memory slave.
// Define WB_ARB_ROUND_ROBIN_EN for round-robin ties; default is fixed m0 priority.
module wb_mem_arbiter #(
    parameter int WB_DWIDTH = 128,
    parameter int WB_SWIDTH = WB_DWIDTH / 8
) (
    input  logic                 sysclk,
    input  logic                 rst,
    input  logic [31:0]          m0_adr,
    input  logic [WB_DWIDTH-1:0] m0_dat_w,
    input  logic [WB_SWIDTH-1:0] m0_sel,
    input  logic                 m0_we,
    input  logic                 m0_cyc,
    input  logic                 m0_stb,
    output logic [WB_DWIDTH-1:0] m0_dat_r,
    output logic                 m0_ack,
    input  logic [31:0]          m1_adr,
    input  logic [WB_DWIDTH-1:0] m1_dat_w,
    input  logic [WB_SWIDTH-1:0] m1_sel,
    input  logic                 m1_we,
    input  logic                 m1_cyc,
    input  logic                 m1_stb,
    output logic [WB_DWIDTH-1:0] m1_dat_r,
    output logic                 m1_ack,
    output logic [31:0]          s_adr,
    output logic [WB_DWIDTH-1:0] s_dat_w,
    output logic [WB_SWIDTH-1:0] s_sel,
    output logic                 s_we,
    output logic                 s_cyc,
    output logic                 s_stb,
    input  logic [WB_DWIDTH-1:0] s_dat_r,
    input  logic                 s_ack,
    output logic [1:0]           grant
);

    // Encoding doubles as the one-hot grant vector {m1,m0}.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } state_e;

    state_e state_q, state_d;

`ifdef WB_ARB_ROUND_ROBIN_EN
    // 1 when m1 was granted most recently.
    logic last_q, last_d;

    // Last-owner register; reset to m1 so m0 wins the first tie.
    always_ff @(posedge sysclk) begin
        if (rst) last_q <= 1'b1;
        else     last_q <= last_d;
    end
`endif

    // Ownership state register.
    always_ff @(posedge sysclk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next owner: grant only from IDLE, hold while owner keeps cyc.
    always_comb begin
        state_d = state_q;
`ifdef WB_ARB_ROUND_ROBIN_EN
        last_d  = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (m0_cyc && m1_cyc) begin
`ifdef WB_ARB_ROUND_ROBIN_EN
                    state_d = last_q ? OWN0 : OWN1;
`else
                    state_d = OWN0;
`endif
                end else if (m0_cyc) begin
                    state_d = OWN0;
                end else if (m1_cyc) begin
                    state_d = OWN1;
                end
            end
            OWN0:    if (!m0_cyc) state_d = IDLE;
            OWN1:    if (!m1_cyc) state_d = IDLE;
            default: state_d = IDLE;
        endcase
`ifdef WB_ARB_ROUND_ROBIN_EN
        if (state_q == IDLE && state_d == OWN0) last_d = 1'b0;
        if (state_q == IDLE && state_d == OWN1) last_d = 1'b1;
`endif
    end

    // Route the owner to the slave; reset masks everything at once.
    always_comb begin
        s_adr   = '0;
        s_dat_w = '0;
        s_sel   = '0;
        s_we    = 1'b0;
        s_cyc   = 1'b0;
        s_stb   = 1'b0;
        m0_ack  = 1'b0;
        m1_ack  = 1'b0;
        if (!rst) begin
            case (state_q)
                OWN0: begin
                    s_adr   = m0_adr;
                    s_dat_w = m0_dat_w;
                    s_sel   = m0_sel;
                    s_we    = m0_we;
                    s_cyc   = m0_cyc;
                    s_stb   = m0_stb;
                    m0_ack  = s_ack;
                end
                OWN1: begin
                    s_adr   = m1_adr;
                    s_dat_w = m1_dat_w;
                    s_sel   = m1_sel;
                    s_we    = m1_we;
                    s_cyc   = m1_cyc;
                    s_stb   = m1_stb;
                    m1_ack  = s_ack;
                end
                default: ;
            endcase
        end
    end

    assign m0_dat_r = s_dat_r;
    assign m1_dat_r = s_dat_r;
    assign grant    = state_q;

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Directed bench for wb_mem_arbiter with per-master response scoreboards.
// Build with +define+WB_ARB_ROUND_ROBIN_EN to check the round-robin variant.
module tb_wb_mem_arbiter;

    typedef struct {
        logic [31:0]  adr;
        logic         we;
        logic [15:0]  sel;
        logic [127:0] wd;
        logic [127:0] rd;
    } exp_t;

    logic         sysclk;
    logic         rst;
    logic         mc[2];
    logic         ms[2];
    logic         mwe[2];
    logic [31:0]  ma[2];
    logic [15:0]  msel[2];
    logic [127:0] mwd[2];
    logic [127:0] m0_dat_r, m1_dat_r, s_dat_w;
    logic         m0_ack, m1_ack;
    logic [31:0]  s_adr;
    logic [15:0]  s_sel;
    logic         s_we, s_cyc, s_stb;
    logic [1:0]   grant;
    logic         s_ack;
    logic [127:0] s_dat_r;
    logic         slave_en;
    logic         spur;

    int n_tests = 0;
    int n_fail  = 0;

    exp_t       q0[$];
    exp_t       q1[$];
    logic [1:0] hist[$];
    int         hlen[$];
    logic [1:0] eh[$];
    logic [1:0] gprev;
    bit         rec;

    function automatic logic [127:0] rdata(input logic [31:0] a);
        if (a == 32'h100) return {4{32'hDEADBEEF}};
        return {4{a ^ 32'hA5A5_0000}};
    endfunction

    // Zero-wait memory slave plus an injectable stray ack.
    assign s_ack   = (s_cyc & s_stb & slave_en) | spur;
    assign s_dat_r = rdata(s_adr);

    wb_mem_arbiter dut (
        .sysclk   (sysclk),
        .rst      (rst),
        .m0_adr   (ma[0]),
        .m0_dat_w (mwd[0]),
        .m0_sel   (msel[0]),
        .m0_we    (mwe[0]),
        .m0_cyc   (mc[0]),
        .m0_stb   (ms[0]),
        .m0_dat_r (m0_dat_r),
        .m0_ack   (m0_ack),
        .m1_adr   (ma[1]),
        .m1_dat_w (mwd[1]),
        .m1_sel   (msel[1]),
        .m1_we    (mwe[1]),
        .m1_cyc   (mc[1]),
        .m1_stb   (ms[1]),
        .m1_dat_r (m1_dat_r),
        .m1_ack   (m1_ack),
        .s_adr    (s_adr),
        .s_dat_w  (s_dat_w),
        .s_sel    (s_sel),
        .s_we     (s_we),
        .s_cyc    (s_cyc),
        .s_stb    (s_stb),
        .s_dat_r  (s_dat_r),
        .s_ack    (s_ack),
        .grant    (grant)
    );

    initial begin
        sysclk = 1'b0;
        forever #5 sysclk = ~sysclk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge sysclk);
        #1;
    endtask

    // Monitor: every master ack pops that master's expected beat.
    task automatic mon(input int id);
        exp_t         e;
        logic [127:0] rd;
        rd = (id == 0) ? m0_dat_r : m1_dat_r;
        if ((id == 0 && q0.size() == 0) || (id == 1 && q1.size() == 0)) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_ack_m%0d: got ack 1 required 0", id);
            return;
        end
        if (id == 0) e = q0.pop_front();
        else         e = q1.pop_front();
        chk($sformatf("m%0d_s_adr", id), 128'(s_adr), 128'(e.adr));
        chk($sformatf("m%0d_s_we", id), 128'(s_we), 128'(e.we));
        chk($sformatf("m%0d_s_sel", id), 128'(s_sel), 128'(e.sel));
        if (e.we) chk($sformatf("m%0d_s_dat_w", id), s_dat_w, e.wd);
        else      chk($sformatf("m%0d_dat_r", id), rd, e.rd);
    endtask

    initial begin
        forever begin
            @(negedge sysclk);
            if (m0_ack && m1_ack) begin
                n_tests++;
                n_fail++;
                $display("FAIL dual_ack: got 11 required one-hot");
            end
            if (m0_ack) mon(0);
            if (m1_ack) mon(1);
        end
    end

    // Compressed grant history with run lengths.
    initial begin
        forever begin
            @(negedge sysclk);
            if (rec) begin
                if (grant != gprev) begin
                    hist.push_back(grant);
                    hlen.push_back(1);
                    gprev = grant;
                end else if (hlen.size() > 0) begin
                    hlen[hlen.size()-1]++;
                end
            end
        end
    end

    task automatic rec_start;
        hist.delete();
        hlen.delete();
        gprev = 2'b00;
        rec   = 1'b1;
    endtask

    task automatic chk_hist(input string nm);
        chk({nm, "_len"}, 128'(hist.size()), 128'(eh.size()));
        for (int i = 0; i < eh.size() && i < hist.size(); i++)
            chk($sformatf("%s_%0d", nm, i), 128'(hist[i]), 128'(eh[i]));
    endtask

    task automatic wait_ack(input int id);
        int n = 0;
        bit got = 1'b0;
        while (!got) begin
            @(negedge sysclk);
            got = (id == 0) ? m0_ack : m1_ack;
            if (!got) begin
                n++;
                if (n > 100) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL ack_timeout_m%0d: got no ack required ack", id);
                    got = 1'b1;
                end else begin
                    tick;
                end
            end
        end
    endtask

    // One locked cycle of nb beats, stb dropped for gap cycles between beats.
    task automatic mreq(input int id, input logic [31:0] adr,
                        input logic we, input int nb, input int gap);
        exp_t e;
        mc[id] = 1'b1;
        for (int b = 0; b < nb; b++) begin
            ma[id]   = adr + 32'(b * 16);
            mwe[id]  = we;
            msel[id] = 16'hFFFF >> b;
            mwd[id]  = {4{adr + 32'(b)}};
            ms[id]   = 1'b1;
            e.adr = ma[id];
            e.we  = we;
            e.sel = msel[id];
            e.wd  = mwd[id];
            e.rd  = rdata(ma[id]);
            if (id == 0) q0.push_back(e);
            else         q1.push_back(e);
            wait_ack(id);
            tick;
            ms[id] = 1'b0;
            if (b != nb - 1) repeat (gap) tick;
        end
        mc[id] = 1'b0;
    endtask

    task automatic mloop(input int id, input logic [31:0] adr, input int n);
        for (int k = 0; k < n; k++) begin
            mreq(id, adr + 32'(k * 16), 1'b0, 1, 0);
            tick;
        end
    endtask

    initial begin
        exp_t e;
        rst = 1'b1;
        slave_en = 1'b1;
        spur = 1'b0;
        rec = 1'b0;
        gprev = 2'b00;
        for (int i = 0; i < 2; i++) begin
            mc[i] = 1'b0; ms[i] = 1'b0; mwe[i] = 1'b0;
            ma[i] = '0; msel[i] = '0; mwd[i] = '0;
        end
        repeat (2) tick;
        @(negedge sysclk);
        chk("rst_grant", 128'(grant), 128'(2'b00));
        chk("rst_s_cyc", 128'(s_cyc), 128'(1'b0));
        chk("rst_s_stb", 128'(s_stb), 128'(1'b0));
        chk("rst_acks", 128'({m1_ack, m0_ack}), 128'(2'b00));
        tick;
        rst = 1'b0;
        tick;

        // Simultaneous requests right after reset: m0 first, one dead cycle, m1.
        rec_start;
        fork
            mreq(0, 32'h200, 1'b0, 1, 0);
            mreq(1, 32'h300, 1'b0, 1, 0);
        join
        repeat (2) tick;
        rec = 1'b0;
        eh = '{2'b01, 2'b00, 2'b10, 2'b00};
        chk_hist("tie_after_rst");
        chk("dead_cycle", 128'(hlen.size() > 1 ? hlen[1] : 0), 128'(1));

        // Both masters repeatedly requesting single beats.
        rec_start;
        fork
            mloop(0, 32'h1000, 3);
            mloop(1, 32'h2000, 3);
        join
        repeat (2) tick;
        rec = 1'b0;
`ifdef WB_ARB_ROUND_ROBIN_EN
        eh = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00,
               2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
`else
        eh = '{2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00,
               2'b10, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00};
`endif
        chk_hist("contend");
        chk("contend_dead", 128'(hlen.size() > 3 ? hlen[3] : 0), 128'(1));

        // Single m0 read answered with DEADBEEF one cycle after request.
        mc[0] = 1'b1; ms[0] = 1'b1; ma[0] = 32'h100;
        mwe[0] = 1'b0; msel[0] = 16'hFFFF; mwd[0] = '0;
        e.adr = 32'h100; e.we = 1'b0; e.sel = 16'hFFFF;
        e.wd = '0; e.rd = {4{32'hDEADBEEF}};
        q0.push_back(e);
        @(negedge sysclk);
        chk("rd_n_grant", 128'(grant), 128'(2'b00));
        chk("rd_n_s_cyc", 128'(s_cyc), 128'(1'b0));
        chk("rd_n_ack", 128'(m0_ack), 128'(1'b0));
        tick;
        @(negedge sysclk);
        chk("rd_n1_grant", 128'(grant), 128'(2'b01));
        chk("rd_n1_m0_ack", 128'(m0_ack), 128'(1'b1));
        chk("rd_n1_m1_ack", 128'(m1_ack), 128'(1'b0));
        chk("rd_m0_dat", 128'(m0_dat_r[31:0]), 128'(32'hDEADBEEF));
        chk("rd_m1_dat", 128'(m1_dat_r[31:0]), 128'(32'hDEADBEEF));
        tick;
        mc[0] = 1'b0; ms[0] = 1'b0;
        @(negedge sysclk);
        chk("release_s_cyc", 128'(s_cyc), 128'(1'b0));
        repeat (2) tick;

        // m1 4-beat write burst with stb gaps while m0 waits.
        rec_start;
        fork
            mreq(1, 32'h400, 1'b1, 4, 2);
            begin
                tick;
                mreq(0, 32'h500, 1'b0, 1, 0);
            end
        join
        repeat (2) tick;
        rec = 1'b0;
        eh = '{2'b10, 2'b00, 2'b01, 2'b00};
        chk_hist("burst");
        chk("burst_hold", 128'(hlen.size() > 0 ? hlen[0] : 0), 128'(11));

        // Stray slave ack while idle, then while a request waits in IDLE.
        spur = 1'b1;
        @(negedge sysclk);
        chk("spur_acks", 128'({m1_ack, m0_ack}), 128'(2'b00));
        tick;
        mc[0] = 1'b1; ms[0] = 1'b1; ma[0] = 32'h600; mwe[0] = 1'b0;
        e.adr = 32'h600; e.we = 1'b0; e.sel = msel[0];
        e.wd = mwd[0]; e.rd = rdata(32'h600);
        q0.push_back(e);
        @(negedge sysclk);
        chk("spur_req_ack", 128'({m1_ack, m0_ack}), 128'(2'b00));
        tick;
        spur = 1'b0;
        wait_ack(0);
        tick;
        mc[0] = 1'b0; ms[0] = 1'b0;
        repeat (2) tick;

        // Reset pulse while m0 owns the bus with stb high.
        slave_en = 1'b0;
        mc[0] = 1'b1; ms[0] = 1'b1; ma[0] = 32'h700;
        @(negedge sysclk);
        chk("rp_idle", 128'(grant), 128'(2'b00));
        tick;
        @(negedge sysclk);
        chk("rp_own", 128'(grant), 128'(2'b01));
        chk("rp_stb", 128'(s_stb), 128'(1'b1));
        tick;
        rst = 1'b1;
        spur = 1'b1;
        @(negedge sysclk);
        chk("rp_rst_ack", 128'(m0_ack), 128'(1'b0));
        tick;
        rst = 1'b0;
        spur = 1'b0;
        @(negedge sysclk);
        chk("rp_after_grant", 128'(grant), 128'(2'b00));
        chk("rp_after_s_cyc", 128'(s_cyc), 128'(1'b0));
        chk("rp_after_ack", 128'(m0_ack), 128'(1'b0));
        tick;
        e.adr = 32'h700; e.we = 1'b0; e.sel = msel[0];
        e.wd = mwd[0]; e.rd = rdata(32'h700);
        q0.push_back(e);
        slave_en = 1'b1;
        @(negedge sysclk);
        chk("rp_regrant", 128'(grant), 128'(2'b01));
        tick;
        mc[0] = 1'b0; ms[0] = 1'b0;
        repeat (2) tick;

        // Reset held high blocks any grant.
        rst = 1'b1;
        mc[1] = 1'b1; ms[1] = 1'b1; ma[1] = 32'h800; mwe[1] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge sysclk);
            chk($sformatf("rh_grant_%0d", k), 128'(grant), 128'(2'b00));
            chk($sformatf("rh_s_cyc_%0d", k), 128'(s_cyc), 128'(1'b0));
            tick;
        end
        rst = 1'b0;
        e.adr = 32'h800; e.we = 1'b0; e.sel = msel[1];
        e.wd = mwd[1]; e.rd = rdata(32'h800);
        q1.push_back(e);
        @(negedge sysclk);
        chk("rh_release_idle", 128'(grant), 128'(2'b00));
        tick;
        @(negedge sysclk);
        chk("rh_grant_m1", 128'(grant), 128'(2'b10));
        tick;
        mc[1] = 1'b0; ms[1] = 1'b0;
        repeat (3) tick;

        chk("q0_drained", 128'(q0.size()), 128'(0));
        chk("q1_drained", 128'(q1.size()), 128'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
